// File: rtl/mano_pkg.sv
// mano_pkg: shared definitions for the mano_cpu memory subsystem.
//   - default data/address widths (also used by mano_cpu)
//   - arbiter state encoding (enum for readability in waveforms, plus
//     plain localparam constants used by the RTL)
//   - requester port identifiers used as read-pipeline tags
package mano_pkg;

  localparam int MANO_DWIDTH = 32;
  localparam int MANO_AWIDTH = 12;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWN_A = 2'd1,
    ST_OWN_B = 2'd2
  } arb_state_e;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWN_A = 2'd1;
  localparam logic [1:0] OWN_B = 2'd2;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/mano_rd_pipe.sv
// mano_rd_pipe: two-stage valid + port-tag shift register for SRAM reads.
// A read accepted at edge N enters stage 0 at edge N; the SRAM samples its
// address at edge N+1, the same edge that moves the tag into stage 1, so
// stage 1 lines up with mem_dout and drives the owning port's rvalid.
// Ports:
//   clk, reset_n   clock, synchronous active-low reset (flushes the pipe)
//   issue          a read was accepted this cycle
//   issue_port     which port owns that read (PORT_A / PORT_B)
//   mem_dout       synchronous SRAM read data
//   a_rvalid/a_rdata, b_rvalid/b_rdata  per-port read return
module mano_rd_pipe
  import mano_pkg::*;
#(
  parameter int DWIDTH = MANO_DWIDTH
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              issue,
  input  logic              issue_port,
  input  logic [DWIDTH-1:0] mem_dout,
  output logic              a_rvalid,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              b_rvalid,
  output logic [DWIDTH-1:0] b_rdata
);

  logic [1:0] vld;
  logic [1:0] tag;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vld <= 2'b00;
      tag <= 2'b00;
    end else begin
      vld <= {vld[0], issue};
      tag <= {tag[0], issue_port};
    end
  end

  assign a_rvalid = vld[1] && (tag[1] == PORT_A);
  assign b_rvalid = vld[1] && (tag[1] == PORT_B);

  // Data is only steered to the port that owns the returning read.
  assign a_rdata = a_rvalid ? mem_dout : '0;
  assign b_rdata = b_rvalid ? mem_dout : '0;

endmodule

// File: rtl/mano_mem_arbiter.sv
// mano_mem_arbiter: two-requester arbiter for the mano_cpu single-port SRAM.
// Port A is the CPU, port B a host loader / data mover. Round-robin between
// the two, with an optional bounded burst lock for B. SRAM controls are
// registered; read data returns two cycles after acceptance.
// Handshake: a request is accepted on a rising edge where req && gnt.
//   gnt is combinational, never high without its req, and at most one gnt
//   is high per cycle. The accepted address/data/we must be stable while
//   req is high before the edge.
// Ports:
//   clk, reset_n                      clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata/a_gnt   port A request side
//   a_rdata/a_rvalid                  port A read return
//   b_* (same) plus b_lock            port B, b_lock requests burst ownership
//   mem_addr/mem_din/mem_we           registered SRAM controls
//   mem_dout                          SRAM read data (1-cycle latency)
module mano_mem_arbiter
  import mano_pkg::*;
#(
  parameter int DWIDTH   = MANO_DWIDTH,
  parameter int AWIDTH   = MANO_AWIDTH,
  parameter int LOCK_MAX = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [AWIDTH-1:0] a_addr,
  input  logic [DWIDTH-1:0] a_wdata,
  output logic              a_gnt,
  output logic [DWIDTH-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [AWIDTH-1:0] b_addr,
  input  logic [DWIDTH-1:0] b_wdata,
  input  logic              b_lock,
  output logic              b_gnt,
  output logic [DWIDTH-1:0] b_rdata,
  output logic              b_rvalid,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_din,
  output logic              mem_we,
  input  logic [DWIDTH-1:0] mem_dout
);

  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX);

  logic [1:0]    state;
  logic          rr_ptr;    // last port served
  logic          served;    // any grant since reset; A wins the first tie
  logic [CW-1:0] lock_cnt;
  logic          grant_a;
  logic          grant_b;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (reset_n) begin
      if (a_req && b_req) begin
        if (lock_cnt == LOCK_LIM) begin
          // B has used its whole burst budget while A waited.
          grant_a = 1'b1;
        end else if ((state == OWN_B) && b_lock) begin
          grant_b = 1'b1;
        end else if (!served || (rr_ptr == PORT_B)) begin
          grant_a = 1'b1;
        end else begin
          grant_b = 1'b1;
        end
      end else begin
        grant_a = a_req;
        grant_b = b_req;
      end
    end
  end

  assign a_gnt = grant_a;
  assign b_gnt = grant_b;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      rr_ptr   <= PORT_A;
      served   <= 1'b0;
      lock_cnt <= '0;
      mem_addr <= '0;
      mem_din  <= '0;
      mem_we   <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (grant_a) begin
        state    <= OWN_A;
        rr_ptr   <= PORT_A;
        served   <= 1'b1;
        mem_addr <= a_addr;
        mem_din  <= a_wdata;
        mem_we   <= a_we;
      end else if (grant_b) begin
        state    <= OWN_B;
        rr_ptr   <= PORT_B;
        served   <= 1'b1;
        mem_addr <= b_addr;
        mem_din  <= b_wdata;
        mem_we   <= b_we;
      end else begin
        state <= IDLE;
      end

      // Only grants that actually held A off count against the burst budget.
      if (grant_a || !b_lock) begin
        lock_cnt <= '0;
      end else if (grant_b && a_req && (lock_cnt != LOCK_LIM)) begin
        lock_cnt <= lock_cnt + CW'(1);
      end
    end
  end

  mano_rd_pipe #(
    .DWIDTH(DWIDTH)
  ) u_rd_pipe (
    .clk       (clk),
    .reset_n   (reset_n),
    .issue     ((grant_a && !a_we) || (grant_b && !b_we)),
    .issue_port(grant_b ? PORT_B : PORT_A),
    .mem_dout  (mem_dout),
    .a_rvalid  (a_rvalid),
    .a_rdata   (a_rdata),
    .b_rvalid  (b_rvalid),
    .b_rdata   (b_rdata)
  );

endmodule

// File: tb/tb_mano_mem_arbiter.sv
// Testbench for mano_mem_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural arbitration/memory model.
module tb_mano_mem_arbiter;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int LOCK_MAX = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset_n;
  logic          a_req, a_we, b_req, b_we, b_lock;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata;
  logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
  logic [DW-1:0] a_rdata, b_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we;
  logic [DW-1:0] mem_dout;

  mano_mem_arbiter #(.DWIDTH(DW), .AWIDTH(AW), .LOCK_MAX(LOCK_MAX)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_gnt(a_gnt), .a_rdata(a_rdata), .a_rvalid(a_rvalid),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_gnt(b_gnt), .b_rdata(b_rdata), .b_rvalid(b_rvalid),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout)
  );

  // Synchronous SRAM, one-cycle read latency.
  logic [DW-1:0] sram [0:4095];
  always @(posedge clk) begin
    if (mem_we) sram[mem_addr] <= mem_din;
    mem_dout <= sram[mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int n_checks = 0;
  logic [DW-1:0] exp_q[$];
  bit            exp_port_q[$];
  int            exp_due_q[$];
  bit            mon_en = 1'b0;

  // Reference model: memory contents and arbitration history.
  logic [DW-1:0] ref_mem [0:4095];
  int m_last;     // 1 = A, 2 = B, last port served
  bit m_any;      // anything served since reset
  bit m_ownb;     // B was granted in the previous cycle
  int m_cnt;      // B grants under lock that held A off
  int a_wait;     // cycles A has been waiting

  bit            pend_acc, pend_we;
  logic [AW-1:0] pend_addr;
  logic [DW-1:0] pend_din;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // 0 = none, 1 = A, 2 = B
  function automatic int model_grant(input bit ar, input bit br, input bit bl);
    if (ar && br) begin
      if (m_cnt >= LOCK_MAX) return 1;
      if (m_ownb && bl) return 2;
      if (!m_any || m_last == 2) return 1;
      return 2;
    end
    if (ar) return 1;
    if (br) return 2;
    return 0;
  endfunction

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (exp_due_q.size() > 0 && exp_due_q[0] == cyc) begin
          logic [DW-1:0] d;
          bit p;
          d = exp_q.pop_front();
          p = exp_port_q.pop_front();
          void'(exp_due_q.pop_front());
          if (p == 1'b0) begin
            chk("a_rvalid", a_rvalid, 1);
            chk("b_rvalid_quiet", b_rvalid, 0);
            chk("a_rdata", a_rdata, d);
          end else begin
            chk("b_rvalid", b_rvalid, 1);
            chk("a_rvalid_quiet", a_rvalid, 0);
            chk("b_rdata", b_rdata, d);
          end
        end else begin
          chk("rvalid_idle", {a_rvalid, b_rvalid}, 0);
        end
      end
    end
  end

  // ---------------- driver ----------------
  task automatic core(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input bit bl);
    int g;
    chk("mem_we", mem_we, pend_we);
    if (pend_acc) chk("mem_addr", mem_addr, pend_addr);
    if (pend_we) chk("mem_din", mem_din, pend_din);
    a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
    b_req = br; b_we = bw; b_addr = ba; b_wdata = bd; b_lock = bl;
    #1;
    g = model_grant(ar, br, bl);
    chk("a_gnt", a_gnt, (g == 1));
    chk("b_gnt", b_gnt, (g == 2));
    if (g == 1) begin
      chk("a_wait_bound", (a_wait <= LOCK_MAX), 1);
      a_wait = 0;
    end else if (ar) begin
      a_wait++;
    end else begin
      a_wait = 0;
    end
    pend_acc = (g != 0);
    pend_we = 1'b0;
    if (g != 0) begin
      logic          w;
      logic [AW-1:0] ad_sel;
      logic [DW-1:0] wd_sel;
      w      = (g == 1) ? aw : bw;
      ad_sel = (g == 1) ? aa : ba;
      wd_sel = (g == 1) ? ad : bd;
      pend_we = w; pend_addr = ad_sel; pend_din = wd_sel;
      if (w) begin
        ref_mem[ad_sel] = wd_sel;
      end else begin
        exp_q.push_back(ref_mem[ad_sel]);
        exp_port_q.push_back(g == 2);
        exp_due_q.push_back(cyc + 2);
      end
      m_last = g;
      m_any = 1'b1;
    end
    if (g == 1 || !bl) m_cnt = 0;
    else if (g == 2 && ar && m_cnt < LOCK_MAX) m_cnt++;
    m_ownb = (g == 2);
  endtask

  task automatic step(input bit ar, input bit aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input bit br, input bit bw, input logic [AW-1:0] ba, input logic [DW-1:0] bd,
                      input bit bl);
    @(negedge clk); #1;
    core(ar, aw, aa, ad, br, bw, ba, bd, bl);
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, '0, '0, 0, 0, '0, '0, 0);
  endtask

  // Reset held with both requests high; release and check the first tie.
  task automatic do_reset(input int n);
    @(negedge clk); #1;
    reset_n = 1'b0;
    a_req = 1'b1; b_req = 1'b1; a_we = 1'b0; b_we = 1'b0; b_lock = 1'b0;
    exp_q.delete(); exp_port_q.delete(); exp_due_q.delete();
    pend_acc = 1'b0; pend_we = 1'b0;
    #1;
    chk("rst_a_gnt", a_gnt, 0);
    chk("rst_b_gnt", b_gnt, 0);
    repeat (n) begin
      @(negedge clk); #1;
      chk("rst_a_gnt", a_gnt, 0);
      chk("rst_b_gnt", b_gnt, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_mem_addr", mem_addr, 0);
      chk("rst_mem_din", mem_din, 0);
      chk("rst_rvalid", {a_rvalid, b_rvalid}, 0);
    end
    m_last = 1; m_any = 1'b0; m_ownb = 1'b0; m_cnt = 0; a_wait = 0;
    reset_n = 1'b1;
    mon_en = 1'b1;
    core(1, 0, '0, '0, 1, 0, '0, '0, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit lk;
    reset_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0; b_lock = 0;
    for (int i = 0; i < 4096; i++) begin
      sram[i] = '0;
      ref_mem[i] = '0;
    end
    do_reset(3);
    idle(3);

    // B write then read back, A idle.
    step(0, 0, '0, '0, 1, 1, 12'h010, 32'hDEAD_BEEF, 0);
    step(0, 0, '0, '0, 1, 0, 12'h010, '0, 0);
    idle(3);

    // Both requesting, no lock: alternating grants.
    for (int i = 0; i < 8; i++)
      step(1, 0, AW'(12'h010 + i), '0, 1, 0, AW'(12'h020 + i), '0, 0);
    idle(3);

    // Preload 0..3 with 1..4, then back-to-back reads.
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 1, AW'(i), DW'(i + 1), 0);
    for (int i = 0; i < 4; i++) step(0, 0, '0, '0, 1, 0, AW'(i), '0, 0);
    idle(3);

    // Burst lock with A held off.
    for (int i = 0; i < 24; i++)
      step(1, 0, AW'(i % 4), '0, 1, (i % 3 == 0), AW'(12'h040 + i), DW'(i * 7), 1);
    for (int i = 0; i < 2; i++) step(1, 0, '0, '0, 1, 0, AW'(12'h040), '0, 0);
    idle(3);

    // Read accepted, then reset in the following cycle.
    step(0, 0, '0, '0, 1, 0, 12'h010, '0, 0);
    do_reset(2);
    idle(2);
    step(0, 0, '0, '0, 1, 0, 12'h010, '0, 0);
    idle(3);

    // Random traffic.
    lk = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) lk = !lk;
      step($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, AW'($urandom_range(0, 15)), $urandom,
           lk);
    end
    idle(4);
    chk("exp_q_drained", exp_due_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
